// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op codes and bundle layouts for the MEM stage.
// Optional feature macro: MS_LWLR_EN (adds rt_old to the EX->MS bus and enables LWL/LWR).
package mem_stage_pkg;

`ifdef MS_LWLR_EN
  localparam int ES_W = 108;
`else
  localparam int ES_W = 76;
`endif
  localparam int MS_W  = 70;
  localparam int FWD_W = 37;

  typedef enum logic [2:0] {
    LD_OP_LW  = 3'd0,
    LD_OP_LB  = 3'd1,
    LD_OP_LBU = 3'd2,
    LD_OP_LH  = 3'd3,
    LD_OP_LHU = 3'd4,
    LD_OP_LWL = 3'd5,
    LD_OP_LWR = 3'd6
  } ld_op_e;

  typedef struct packed {
`ifdef MS_LWLR_EN
    logic [31:0] rt_old;
`endif
    logic [2:0]  ld_op;
    logic [1:0]  addr_lo;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_bus_t;

  // Extends either the low byte or the full half of val to 32 bits.
  function automatic logic [31:0] load_extend(input logic [15:0] val,
                                              input logic        is_half,
                                              input logic        signed_ld);
    logic fill;
    fill = signed_ld & (is_half ? val[15] : val[7]);
    if (is_half) return {{16{fill}}, val};
    return {{24{fill}}, val[7:0]};
  endfunction

endpackage

// File: rtl/ms_load_align.sv
// Combinational load alignment: selects byte/half/word lanes of the raw read data and extends them.
// Optional feature macro: MS_LWLR_EN (LWL/LWR merge with rt_old; otherwise ops 5/6 act as LW).
module ms_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] ld_raw,
`ifdef MS_LWLR_EN
  input  logic [31:0] rt_old,
`endif
  output logic [31:0] ld_ext
);

  logic [7:0]  raw_bytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign raw_bytes[gi] = ld_raw[8*gi +: 8];
  end

  assign byte_sel = raw_bytes[addr_lo];
  // addr_lo[0] is ignored for halves; misaligned halves never reach this stage.
  assign half_sel = {raw_bytes[{addr_lo[1], 1'b1}], raw_bytes[{addr_lo[1], 1'b0}]};

`ifdef MS_LWLR_EN
  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;
  logic [31:0] lwl_mask;
  logic [31:0] lwr_mask;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  // LWL shifts the low bytes of memory up into rt; LWR shifts the high bytes down.
  assign lwl_sh   = {2'd3 - addr_lo, 3'b000};
  assign lwr_sh   = {addr_lo, 3'b000};
  assign lwl_mask = 32'hFFFF_FFFF << lwl_sh;
  assign lwr_mask = 32'hFFFF_FFFF >> lwr_sh;
  assign lwl_val  = (ld_raw << lwl_sh) | (rt_old & ~lwl_mask);
  assign lwr_val  = (ld_raw >> lwr_sh) | (rt_old & ~lwr_mask);
`endif

  always_comb begin
    ld_ext = ld_raw;
    case (ld_op)
      LD_OP_LB:  ld_ext = load_extend({8'h00, byte_sel}, 1'b0, 1'b1);
      LD_OP_LBU: ld_ext = load_extend({8'h00, byte_sel}, 1'b0, 1'b0);
      LD_OP_LH:  ld_ext = load_extend(half_sel, 1'b1, 1'b1);
      LD_OP_LHU: ld_ext = load_extend(half_sel, 1'b1, 1'b0);
`ifdef MS_LWLR_EN
      LD_OP_LWL: ld_ext = lwl_val;
      LD_OP_LWR: ld_ext = lwr_val;
`endif
      default:   ld_ext = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one-entry handshake register, SRAM read-data hold buffer, result mux and forwarding.
// Optional feature macro: MS_LWLR_EN (carries rt_old through to the load aligner).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             ms_allowin,
  input  logic             es_to_ms_valid,
  input  logic [ES_W-1:0]  es_to_ms_bus,
  input  logic             ws_allowin,
  output logic             ms_to_ws_valid,
  output logic [MS_W-1:0]  ms_to_ws_bus,
  output logic [FWD_W-1:0] ms_blocking,
  input  logic [31:0]      data_sram_rdata
);

  logic        ms_valid;
  es_bus_t     bus_r;
  logic        rdata_buf_vld;
  logic [31:0] rdata_buf;

  logic        ms_ready_go;
  logic        capture;
  logic [31:0] ld_raw;
  logic [31:0] ld_ext;
  logic [31:0] final_result;
  ms_bus_t     ms_bus;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // The SRAM presents load data for one cycle only; keep it while WB stalls.
  assign capture = ms_valid && bus_r.res_from_mem && !rdata_buf_vld && !ws_allowin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid      <= 1'b0;
      bus_r         <= '0;
      rdata_buf_vld <= 1'b0;
      rdata_buf     <= 32'h0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        bus_r <= es_to_ms_bus;
      end
      if (ms_allowin) begin
        rdata_buf_vld <= 1'b0;
      end else if (capture) begin
        rdata_buf_vld <= 1'b1;
        rdata_buf     <= data_sram_rdata;
      end
    end
  end

  assign ld_raw = rdata_buf_vld ? rdata_buf : data_sram_rdata;

  ms_load_align u_load_align (
    .ld_op   (bus_r.ld_op),
    .addr_lo (bus_r.addr_lo),
    .ld_raw  (ld_raw),
`ifdef MS_LWLR_EN
    .rt_old  (bus_r.rt_old),
`endif
    .ld_ext  (ld_ext)
  );

  always_comb begin
    final_result = bus_r.alu_result;
    if (bus_r.res_from_mem) begin
      final_result = ld_ext;
    end
  end

  always_comb begin
    ms_bus              = '0;
    ms_bus.gr_we        = bus_r.gr_we;
    ms_bus.dest         = bus_r.dest;
    ms_bus.final_result = final_result;
    ms_bus.pc           = bus_r.pc;
  end

  assign ms_to_ws_bus = ms_bus;

  // Forwarding stays live while stalled; r0 writes and empty slots forward nothing.
  assign ms_blocking = (ms_valid && bus_r.gr_we && (bus_r.dest != 5'd0))
                     ? {bus_r.dest, final_result} : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by a randomized run against a slot-level model.
// Builds with or without MS_LWLR_EN.
module tb_mem_stage;
  import mem_stage_pkg::*;

`ifdef MS_LWLR_EN
  localparam bit LWLR = 1'b1;
`else
  localparam bit LWLR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             ms_allowin;
  logic             es_to_ms_valid;
  logic [ES_W-1:0]  es_to_ms_bus;
  logic             ws_allowin;
  logic             ms_to_ws_valid;
  logic [MS_W-1:0]  ms_to_ws_bus;
  logic [FWD_W-1:0] ms_blocking;
  logic [31:0]      data_sram_rdata;
  logic [31:0]      cur_rt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_blocking     (ms_blocking),
    .data_sram_rdata (data_sram_rdata)
  );

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rt_old comes from cur_rt so that the same call works in both builds.
  function automatic logic [ES_W-1:0] mk_bus(input logic [2:0] op, input logic [1:0] a,
                                             input logic rfm, input logic we, input logic [4:0] d,
                                             input logic [31:0] alu, input logic [31:0] pc);
`ifdef MS_LWLR_EN
    return {cur_rt, op, a, rfm, we, d, alu, pc};
`else
    return {op, a, rfm, we, d, alu, pc};
`endif
  endfunction

  // Reference load semantics written from the byte-lane rules.
  function automatic logic [31:0] ref_load(input int op, input int a,
                                           input logic [31:0] raw, input logic [31:0] rt);
    logic [7:0]  rb [4];
    logic [7:0]  ob [4];
    int          b;
    int          h;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      rb[i] = raw[8*i +: 8];
      ob[i] = rt[8*i +: 8];
    end
    b = int'(rb[a]);
    h = int'({rb[2*(a/2)+1], rb[2*(a/2)]});
    r = raw;
    case (op)
      1: r = 32'(b >= 128 ? b - 256 : b);
      2: r = 32'(b);
      3: r = 32'(h >= 32768 ? h - 65536 : h);
      4: r = 32'(h);
      5: if (LWLR) begin
           for (int i = 0; i < 4; i++) if (i >= 3 - a) ob[i] = rb[i - (3 - a)];
           r = {ob[3], ob[2], ob[1], ob[0]};
         end
      6: if (LWLR) begin
           for (int i = 0; i < 4; i++) if (i <= 3 - a) ob[i] = rb[i + a];
           r = {ob[3], ob[2], ob[1], ob[0]};
         end
      default: r = raw;
    endcase
    return r;
  endfunction

  typedef struct {
    int          op;
    int          a;
    bit          rfm;
    bit          we;
    logic [4:0]  d;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rt;
  } bundle_t;

  initial begin
    logic [2:0]  ld_ops [5];
    logic [1:0]  ld_as  [5];
    logic [31:0] ld_exp [5];
    bundle_t     cb;
    bundle_t     nb;
    bit          mv;
    bit          first;
    logic [31:0] raw;
    logic [31:0] exp_res;

    ld_ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    ld_as  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    ld_exp = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

    reset           = 1'b1;
    es_to_ms_valid  = 1'b0;
    cur_rt          = 32'h0;
    es_to_ms_bus    = '0;
    ws_allowin      = 1'b1;
    data_sram_rdata = 32'h0;
    #2;
    check("rst_allowin", ms_allowin, 1);
    check("rst_valid", ms_to_ws_valid, 0);
    check("rst_bus", ms_to_ws_bus, 0);
    check("rst_blocking", ms_blocking, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Non-load pass-through
    es_to_ms_bus   = mk_bus(3'd0, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'hBFC0_0010);
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
    #1;
    check("pass_valid", ms_to_ws_valid, 1);
    check("pass_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234, 32'hBFC0_0010});
    check("pass_blocking", ms_blocking, {5'd5, 32'h1234});
    step();
    check("stale_valid", ms_to_ws_valid, 0);
    check("stale_blocking", ms_blocking, 0);
    check("idle_allowin", ms_allowin, 1);

    // Load extension on rdata 0x80FF7F01
    for (int k = 0; k < 5; k++) begin
      es_to_ms_bus   = mk_bus(ld_ops[k], ld_as[k], 1'b1, 1'b1, 5'd9, 32'h5555_0000, 32'h100 + 32'(4*k));
      es_to_ms_valid = 1'b1;
      step();
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = 32'h80FF_7F01;
      #1;
      check($sformatf("ld_ext_op%0d", ld_ops[k]), ms_to_ws_bus[63:32], ld_exp[k]);
      check("ld_blocking", ms_blocking, {5'd9, ld_exp[k]});
      step();
    end

`ifdef MS_LWLR_EN
    cur_rt = 32'hAABB_CCDD;
    es_to_ms_bus   = mk_bus(3'd5, 2'd1, 1'b1, 1'b1, 5'd3, 32'h0, 32'h200);
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_bus   = mk_bus(3'd6, 2'd2, 1'b1, 1'b1, 5'd3, 32'h0, 32'h204);
    data_sram_rdata = 32'h4433_2211;
    #1;
    check("lwl", ms_to_ws_bus[63:32], 32'h2211_CCDD);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    check("lwr", ms_to_ws_bus[63:32], 32'hAABB_4433);
    step();
`endif

    // WB stall on a load: data from the first MS cycle must persist
    es_to_ms_bus   = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd7, 32'h0, 32'h300);
    es_to_ms_valid = 1'b1;
    step();
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    es_to_ms_bus    = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd8, 32'h0, 32'h304);
    #1;
    check("stall_res_c1", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    check("stall_allowin_c1", ms_allowin, 0);
    for (int c = 2; c <= 3; c++) begin
      step();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      check($sformatf("stall_res_c%0d", c), ms_to_ws_bus[63:32], 32'hCAFE_F00D);
      check($sformatf("stall_allowin_c%0d", c), ms_allowin, 0);
      check($sformatf("stall_pc_c%0d", c), ms_to_ws_bus[31:0], 32'h300);
    end
    ws_allowin = 1'b1;
    #1;
    check("release_res", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    check("release_allowin", ms_allowin, 1);
    step();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h1111_2222;
    #1;
    check("replace_pc", ms_to_ws_bus[31:0], 32'h304);
    check("replace_res", ms_to_ws_bus[63:32], 32'h1111_2222);
    step();

    // Back-to-back, no bubbles
    for (int k = 0; k < 4; k++) begin
      es_to_ms_bus   = mk_bus(3'd0, 2'd0, 1'b0, 1'b1, 5'd2, 32'(k), 32'h2000 + 32'(4*k));
      es_to_ms_valid = 1'b1;
      step();
      check($sformatf("b2b_valid%0d", k), ms_to_ws_valid, 1);
      check($sformatf("b2b_pc%0d", k), ms_to_ws_bus[31:0], 32'h2000 + 32'(4*k));
    end
    es_to_ms_valid = 1'b0;
    step();
    check("b2b_drain", ms_to_ws_valid, 0);

    // Forwarding masks
    es_to_ms_bus   = mk_bus(3'd0, 2'd0, 1'b0, 1'b1, 5'd0, 32'h77, 32'h400);
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_bus   = mk_bus(3'd0, 2'd0, 1'b0, 1'b0, 5'd3, 32'h78, 32'h404);
    check("fwd_r0_valid", ms_to_ws_valid, 1);
    check("fwd_r0_blocking", ms_blocking, 0);
    step();
    es_to_ms_valid = 1'b0;
    check("fwd_nowe_blocking", ms_blocking, 0);
    step();

    // Async reset while a load is held
    es_to_ms_bus   = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd4, 32'h0, 32'h500);
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid  = 1'b0;
    ws_allowin      = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    step();
    check("hold_blocking", ms_blocking, {5'd4, 32'h1234_5678});
    #2;
    reset = 1'b1;
    #1;
    check("areset_valid", ms_to_ws_valid, 0);
    check("areset_blocking", ms_blocking, 0);
    check("areset_allowin", ms_allowin, 1);
    @(negedge clk);
    reset      = 1'b0;
    ws_allowin = 1'b1;
    step();

    // Randomized run against the slot model
    mv    = 1'b0;
    first = 1'b0;
    raw   = 32'h0;
    cb    = '{default: 0};
    for (int t = 0; t < 400; t++) begin
      ws_allowin      = ($urandom_range(0, 3) != 0);
      data_sram_rdata = $urandom;
      es_to_ms_valid  = $urandom_range(0, 1) == 1;
      nb.op  = int'($urandom_range(0, 7));
      nb.a   = int'($urandom_range(0, 3));
      nb.rfm = $urandom_range(0, 1) == 1;
      nb.we  = $urandom_range(0, 3) != 0;
      nb.d   = 5'($urandom_range(0, 31));
      nb.alu = $urandom;
      nb.pc  = $urandom;
      nb.rt  = $urandom;
      cur_rt = nb.rt;
      es_to_ms_bus = mk_bus(3'(nb.op), 2'(nb.a), nb.rfm, nb.we, nb.d, nb.alu, nb.pc);
      #1;
      if (mv && first) begin
        raw   = data_sram_rdata;
        first = 1'b0;
      end
      check("rnd_allowin", ms_allowin, !mv || ws_allowin);
      check("rnd_valid", ms_to_ws_valid, mv);
      exp_res = cb.rfm ? ref_load(cb.op, cb.a, raw, cb.rt) : cb.alu;
      if (mv) begin
        check("rnd_bus", ms_to_ws_bus, {cb.we, cb.d, exp_res, cb.pc});
      end
      check("rnd_blocking", ms_blocking, (mv && cb.we && cb.d != 5'd0) ? {cb.d, exp_res} : 37'h0);
      if (!mv || ws_allowin) begin
        mv = es_to_ms_valid;
        if (es_to_ms_valid) begin
          cb    = nb;
          first = 1'b1;
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
